// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter: per-VC FIFOs round-robin arbitrated onto one registered valid/ready output
// Ports: clk/reset (async, active-high); in_valid/in_vc/in_data write a flit into a VC FIFO;
// full/empty/occupancy/error report per-VC state (err_clr clears error);
// out_valid/out_data/out_vc/out_ready form the downstream handshake.
module vc_output_arbiter #(
  parameter int DATA_W   = 10,
  parameter int DEPTH    = 32,
  parameter int NUM_VC   = 5,
  parameter int PKT_MODE = 0,
  parameter int TAIL_BIT = DATA_W - 1,
  localparam int VCW = $clog2(NUM_VC),
  localparam int CW  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [VCW-1:0]       in_vc,
  input  logic [DATA_W-1:0]    in_data,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC*CW-1:0] occupancy,
  output logic [NUM_VC-1:0]    error,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [VCW-1:0]       out_vc,
  input  logic                 out_ready
);
  localparam int PW = CW - 1;
  logic [DATA_W-1:0] mem_q [NUM_VC][DEPTH];
  logic [PW-1:0] wr_ptr_q [NUM_VC];
  logic [PW-1:0] wr_ptr_d [NUM_VC];
  logic [PW-1:0] rd_ptr_q [NUM_VC];
  logic [PW-1:0] rd_ptr_d [NUM_VC];
  logic [CW-1:0] cnt_q [NUM_VC];
  logic [CW-1:0] cnt_d [NUM_VC];
  logic [NUM_VC-1:0] err_q, err_d, wr_en, rd_en, err_set, allow;
  logic [VCW-1:0] last_grant_q, last_grant_d, lock_vc_q, lock_vc_d, out_vc_q, out_vc_d, gnt_vc, idx;
  logic lock_q, lock_d, out_valid_q, out_valid_d, gnt_found, load, grant;
  logic [DATA_W-1:0] out_data_q, out_data_d, head;

  genvar i;
  for (i = 0; i < NUM_VC; i++) begin : g_flags
    assign full[i] = cnt_q[i] == CW'(DEPTH);
    assign empty[i] = cnt_q[i] == '0;
    assign occupancy[i*CW +: CW] = cnt_q[i];
  end
  assign error = err_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_vc = out_vc_q;

  // Round robin starting one past last_grant; a held packet lock masks all but lock_vc.
  always_comb begin
    load = !out_valid_q || out_ready;
    allow = lock_q ? ~empty & (NUM_VC'(1) << lock_vc_q) : ~empty;
    gnt_found = 1'b0;
    gnt_vc = '0;
    idx = last_grant_q;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = idx == VCW'(NUM_VC - 1) ? '0 : idx + VCW'(1);
      if (!gnt_found && allow[idx]) begin
        gnt_found = 1'b1;
        gnt_vc = idx;
      end
    end
    grant = load && gnt_found;
    head = mem_q[gnt_vc][rd_ptr_q[gnt_vc]];
  end

  always_comb begin
    for (int k = 0; k < NUM_VC; k++) begin
      wr_en[k] = in_valid && in_vc == VCW'(k) && !full[k];
      err_set[k] = in_valid && in_vc == VCW'(k) && full[k];
      rd_en[k] = grant && gnt_vc == VCW'(k);
      wr_ptr_d[k] = wr_ptr_q[k] + PW'(wr_en[k]);
      rd_ptr_d[k] = rd_ptr_q[k] + PW'(rd_en[k]);
      cnt_d[k] = cnt_q[k] + CW'(wr_en[k]) - CW'(rd_en[k]);
    end
    err_d = err_clr ? '0 : err_q | err_set;
    out_valid_d = load ? gnt_found : out_valid_q;
    out_data_d = grant ? head : out_data_q;
    out_vc_d = grant ? gnt_vc : out_vc_q;
    last_grant_d = grant ? gnt_vc : last_grant_q;
    lock_d = grant ? (PKT_MODE != 0 && !head[TAIL_BIT]) : lock_q;
    lock_vc_d = grant ? gnt_vc : lock_vc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_VC; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      err_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_vc_q <= '0;
      last_grant_q <= VCW'(NUM_VC - 1);
      lock_q <= 1'b0;
      lock_vc_q <= '0;
    end else begin
      for (int k = 0; k < NUM_VC; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      err_q <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_vc_q <= out_vc_d;
      last_grant_q <= last_grant_d;
      lock_q <= lock_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  // Flit storage needs no reset: the counts define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_VC; k++)
      if (wr_en[k]) mem_q[k][wr_ptr_q[k]] <= in_data;
  end
endmodule
